// File: rtl/boot_pkg.sv
// boot_pkg: shared defaults and FSM state encoding for the boot ROM shadow copier.
package boot_pkg;
    localparam int BOOT_LEN = 128;
    localparam logic [20:0] BOOT_DEST = 21'h000000;
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LATCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/boot_copier.sv
// boot_copier: copies LEN bytes of boot ROM into SRAM after reset, holding the CPU
// in reset until done and accumulating a mod-256 checksum of the image.
module boot_copier
    import boot_pkg::*;
#(
    parameter int LEN = BOOT_LEN,
    parameter logic [20:0] DEST_BASE = BOOT_DEST,
    parameter int WE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reboot,
    output logic [13:0] rom_a,
    input  logic [7:0]  rom_dout,
    output logic [20:0] sram_a,
    output logic [7:0]  sram_dout,
    output logic        sram_we,
    output logic        cpu_hold,
    output logic        done,
    output logic [7:0]  checksum
);
    state_t      state;
    logic [13:0] idx;
    logic [3:0]  wcnt;

    assign rom_a = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            idx       <= '0;
            sram_a    <= DEST_BASE;
            sram_dout <= '0;
            sram_we   <= 1'b0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            checksum  <= '0;
            wcnt      <= '0;
        end else if (reboot) begin
            // address/data are left as-is; an in-flight write is simply dropped
            state    <= ST_FETCH;
            idx      <= '0;
            sram_we  <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            checksum <= '0;
            wcnt     <= '0;
        end else begin
            case (state)
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    sram_dout <= rom_dout;
                    sram_a    <= DEST_BASE + {7'd0, idx};
                    checksum  <= checksum + rom_dout;
                    sram_we   <= 1'b1;
                    wcnt      <= '0;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wcnt == 4'(WE_CYCLES - 1)) begin
                        sram_we <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (idx == 14'(LEN - 1)) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        idx   <= idx + 14'd1;
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
- Shadows the 128-byte bootloader ROM into external SRAM after every reset, so the CPU boots from RAM.
- Sits directly downstream of the bootloader ROM. It drives the ROM address, consumes the ROM's registered data byte, and writes each byte to SRAM.
- Holds the CPU in reset until the copy completes.
- Exposes an 8-bit additive checksum of the copied image for the boot diagnostics register.

Parameters:
- LEN, 128, bytes to copy (1..16384); source ROM addresses 0..LEN-1.
- DEST_BASE, 21'h000000, SRAM address receiving ROM byte 0.
- WE_CYCLES, 2, cycles sram_we is held per byte (1..15) to meet SRAM write pulse width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- reboot  in  1  single-cycle pulse; restarts the copy from byte 0.
- rom_a  out  14  ROM address, driven combinationally from the index register.
- rom_dout  in  8  ROM data; valid one clock after rom_a is stable.
- sram_a  out  21  SRAM write address (registered).
- sram_dout  out  8  SRAM write data (registered).
- sram_we  out  1  SRAM write strobe, active high (registered).
- cpu_hold  out  1  1 = CPU held in reset (registered).
- done  out  1  1 = image copied; stays high until rst or reboot.
- checksum  out  8  mod-256 sum of bytes written so far.

Behaviour:
- Reset values (rst=1 at a posedge): state=FETCH, idx=0, rom_a=0, sram_a=DEST_BASE, sram_dout=0, sram_we=0, cpu_hold=1, done=0, checksum=0, wcnt=0.
- Reset mid-copy: same values; the copy restarts from 0 on the first cycle after rst falls.
- States:
  - FETCH (1 cycle): rom_a=idx; the ROM samples the address at the end of this cycle.
  - LATCH (1 cycle): sram_dout<=rom_dout, sram_a<=DEST_BASE+idx, checksum<=checksum+rom_dout; go to WRITE with sram_we<=1.
  - WRITE (WE_CYCLES cycles): sram_we=1; address and data stable; wcnt counts to WE_CYCLES-1, then sram_we<=0 and go to GAP.
  - GAP (1 cycle): sram_we=0; address and data held, giving hold time.
    - If idx==LEN-1: go to DONE with done<=1 and cpu_hold<=0.
    - Else: idx<=idx+1 and go to FETCH.
  - DONE: idle; rom_a stays at LEN-1; all strobes low. Leaves only on rst or reboot.
- Throughput: WE_CYCLES+3 cycles per byte.
- Latency: done and cpu_hold=0 appear LEN*(WE_CYCLES+3) cycles after the first cycle with rst=0. With defaults that is cycle 640.
- sram_we is never high in FETCH, LATCH, GAP or DONE.
- sram_a and sram_dout never change while sram_we=1.
- reboot (any state, rst=0): next state=FETCH, idx=0, checksum=0, done=0, cpu_hold=1, sram_we=0 immediately.
  - If reboot lands in WRITE, that partial write is abandoned. The byte is rewritten on the next pass.
- rst and reboot together: rst wins; the result is the same state either way.
- Arithmetic:
  - idx is 14 bits and does not wrap below LEN.
  - DEST_BASE+idx is 21 bits, wrapping modulo 2^21.
  - checksum wraps modulo 256.
- LEN=1: a single byte is copied, then DONE.

Decomposition:
- Shared package boot_pkg:
  - state encoding constants ST_FETCH, ST_LATCH, ST_WRITE, ST_GAP, ST_DONE (3-bit);
  - default BOOT_LEN=128 and BOOT_DEST=21'h000000, which are also used by the top level and the ROM size.
- No sub-module: one FSM plus counters in a single module.
- The ROM remains a separate instance wired at the top level.

Test Plan:
1. Defaults, ROM byte i = i^8'hA5, release rst:
   - SRAM model shows bytes 0..127 at 0x000000..0x00007F with matching values;
   - done and cpu_hold=0 first seen at cycle 640;
   - checksum equals the mod-256 sum of all 128 bytes.
2. Write-strobe protocol for the same run:
   - each sram_we pulse lasts exactly 2 cycles;
   - 128 pulses in total;
   - sram_a/sram_dout stable throughout each pulse and its following GAP cycle;
   - sram_we is never high after done.
3. Mid-copy reboot pulse during WRITE of byte 50:
   - next cycle sram_we=0, done=0, checksum=0, rom_a=0;
   - full copy then completes 640 cycles after the pulse with correct contents.
4. rst asserted for 3 cycles while at byte 90, then released:
   - outputs hold their reset values during rst;
   - copy restarts at byte 0, done at cycle 640 after release;
   - reboot asserted together with rst behaves identically.
5. LEN=1, DEST_BASE=21'h1FFFFF, WE_CYCLES=1:
   - one write to 0x1FFFFF with ROM byte 0;
   - done at cycle 4;
   - checksum equals that byte.
6. In DONE, pulse reboot twice 10 cycles apart:
   - the second pulse restarts the copy again;
   - done rises only after an uninterrupted 640-cycle pass.
